// File: rtl/float_to_fixed_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : float_to_fixed_converter_pkg
// Brief   : IEEE-754 single-precision field constants and converter FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package float_to_fixed_converter_pkg;

    localparam int          FP_BIAS        = 127;
    localparam int          FP_EXP_W       = 8;
    localparam int          FP_MAN_W       = 23;
    localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SHIFT  = 3'd2,
        S_FIX    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/float_to_fixed_converter_fp_unpack.sv
`default_nettype none
// ============================================================================
// Module  : float_to_fixed_converter_fp_unpack
// Brief   : Splits a single-precision float into fields and classifies it.
// Revision: 1.0 - initial release
// ============================================================================
module float_to_fixed_converter_fp_unpack
    import float_to_fixed_converter_pkg::*;
(
    input  logic [31:0]         i_float,
    output logic                o_sign,
    output logic [FP_EXP_W-1:0] o_exp,
    output logic [FP_MAN_W-1:0] o_man,
    output logic                o_is_zero,
    output logic                o_is_nan,
    output logic                o_is_inf
);

    assign o_sign    = i_float[31];
    assign o_exp     = i_float[30:23];
    assign o_man     = i_float[22:0];
    // Denormals are flushed to zero along with true zeros.
    assign o_is_zero = (o_exp == '0);
    assign o_is_nan  = (o_exp == FP_EXP_SPECIAL) && (o_man != '0);
    assign o_is_inf  = (o_exp == FP_EXP_SPECIAL) && (o_man == '0);

endmodule

`default_nettype wire

// File: rtl/float_to_fixed_converter.sv
`default_nettype none
// ============================================================================
// Module  : float_to_fixed_converter
// Brief   : Multi-cycle IEEE-754 single to signed Q(WIDTH-FRAC_BITS).FRAC_BITS.
// Revision: 1.0 - initial release
// ============================================================================
module float_to_fixed_converter
    import float_to_fixed_converter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_float_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_fixed_out,
    output logic             o_ovf,
    output logic             o_invalid
);

    localparam int                MAG_W     = WIDTH + 1;
    localparam logic signed [9:0] C_SH_OFF  = 10'(FRAC_BITS - FP_BIAS - FP_MAN_W);
    localparam logic signed [9:0] C_SH_MAX  = 10'(MAG_W - 24);
    localparam logic [MAG_W-1:0]  C_POS_LIM = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [MAG_W-1:0]  C_NEG_LIM = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  C_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]  C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                  r_state;
    logic [31:0]             r_float;
    logic                    r_sign;
    logic                    r_is_zero;
    logic                    r_is_nan;
    logic                    r_is_inf;
    logic [23:0]             r_mant24;
    logic signed [9:0]       r_sh;
    logic [MAG_W-1:0]        r_mag;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [WIDTH-1:0]        r_fixed;
    logic                    r_ovf;
    logic                    r_invalid;

    logic                    w_sign;
    logic [FP_EXP_W-1:0]     w_exp;
    logic [FP_MAN_W-1:0]     w_man;
    logic                    w_is_zero;
    logic                    w_is_nan;
    logic                    w_is_inf;
    logic signed [9:0]       w_sh;
    logic [MAG_W-1:0]        w_mant_ext;
    logic [4:0]              w_rsh;
    logic [MAG_W-1:0]        w_mag;
    logic [WIDTH-1:0]        w_fixed;
    logic                    w_ovf;
    logic                    w_invalid;

    float_to_fixed_converter_fp_unpack u_unpack (
        .i_float   (r_float),
        .o_sign    (w_sign),
        .o_exp     (w_exp),
        .o_man     (w_man),
        .o_is_zero (w_is_zero),
        .o_is_nan  (w_is_nan),
        .o_is_inf  (w_is_inf)
    );

    assign w_sh       = $signed({2'b00, w_exp}) + C_SH_OFF;
    assign w_mant_ext = {{(MAG_W-24){1'b0}}, r_mant24};

    // Oversized left shifts clamp to all-ones so the saturation check still trips.
    always_comb begin
        w_mag = '0;
        w_rsh = 5'(-r_sh);
        if (r_sh > C_SH_MAX) begin
            w_mag = '1;
        end else if (r_sh >= 0) begin
            w_mag = w_mant_ext << r_sh[5:0];
        end else if (r_sh > -10'sd24) begin
            w_mag = w_mant_ext >> w_rsh;
        end
    end

    always_comb begin
        w_fixed   = '0;
        w_ovf     = 1'b0;
        w_invalid = 1'b0;
        if (r_is_nan) begin
            w_invalid = 1'b1;
        end else if (r_is_zero) begin
            w_fixed = '0;
        end else if (!r_sign) begin
            if (r_is_inf || (r_mag > C_POS_LIM)) begin
                w_fixed = C_MAX;
                w_ovf   = 1'b1;
            end else begin
                w_fixed = r_mag[WIDTH-1:0];
            end
        end else if (r_is_inf || (r_mag > C_NEG_LIM)) begin
            w_fixed = C_MIN;
            w_ovf   = 1'b1;
        end else begin
            w_fixed = -r_mag[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_float     <= '0;
            r_sign      <= 1'b0;
            r_is_zero   <= 1'b0;
            r_is_nan    <= 1'b0;
            r_is_inf    <= 1'b0;
            r_mant24    <= '0;
            r_sh        <= '0;
            r_mag       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_fixed     <= '0;
            r_ovf       <= 1'b0;
            r_invalid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_float    <= i_float_in;
                        r_in_ready <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_sign    <= w_sign;
                    r_is_zero <= w_is_zero;
                    r_is_nan  <= w_is_nan;
                    r_is_inf  <= w_is_inf;
                    r_mant24  <= {1'b1, w_man};
                    r_sh      <= w_sh;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_mag   <= w_mag;
                    r_state <= S_FIX;
                end
                S_FIX: begin
                    r_fixed     <= w_fixed;
                    r_ovf       <= w_ovf;
                    r_invalid   <= w_invalid;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_fixed     <= '0;
                        r_ovf       <= 1'b0;
                        r_invalid   <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_fixed_out = r_fixed;
    assign o_ovf       = r_ovf;
    assign o_invalid   = r_invalid;

endmodule

`default_nettype wire
